// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin frame scheduler feeding the uart_tx serializer.
// Two byte requesters are arbitrated round-robin. The granted byte is held on
// tx_data for the whole frame while tx_ctrl sequences start, 9 sending cycles
// (8 data bits and the stop bit) and a GAP_CYCLES idle gap.
// Ports: clk, reset (async, active-high); req0/req1 valid/data in, ready out;
//   tx_data/tx_ctrl out to uart_tx; state_tx_sending/state_tx_en in from it;
//   busy, grant_id, proto_err (sticky) status outputs.
// Option: UART_TX_SCHED_CNT_EN adds frames_sent[15:0], a wrapping frame count.
module uart_tx_sched #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic [7:0] tx_ctrl,
  input  logic       state_tx_sending,
  input  logic       state_tx_en,
  output logic       busy,
  output logic       grant_id,
  output logic       proto_err
`ifdef UART_TX_SCHED_CNT_EN
  ,
  output logic [15:0] frames_sent
`endif
);

  localparam int GW = (GAP_CYCLES > 0) ?
                      $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_GAP
  } state_t;

  state_t        r_state, w_state;
  logic [7:0]    r_tx_ctrl, w_tx_ctrl;
  logic [7:0]    r_tx_data, w_tx_data;
  logic          r_rdy0, w_rdy0;
  logic          r_rdy1, w_rdy1;
  logic          r_busy, w_busy;
  logic          r_gid, w_gid;
  logic          r_rr, w_rr;
  logic [3:0]    r_bit, w_bit;
  logic [GW-1:0] r_gap, w_gap;
  logic          r_err, w_err;
  logic          r_first, w_first;
  logic          r_idle_hi, w_idle_hi;
  logic          w_win1;
  logic          w_done;

  // uart_tx's tx_en echo carries no extra information here.
  logic w_unused_en;
  assign w_unused_en = state_tx_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tx_ctrl <= 8'h00;
      r_tx_data <= 8'h00;
      r_rdy0    <= 1'b0;
      r_rdy1    <= 1'b0;
      r_busy    <= 1'b0;
      r_gid     <= 1'b0;
      r_rr      <= 1'b1;
      r_bit     <= 4'd0;
      r_gap     <= '0;
      r_err     <= 1'b0;
      r_first   <= 1'b0;
      r_idle_hi <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_tx_ctrl <= w_tx_ctrl;
      r_tx_data <= w_tx_data;
      r_rdy0    <= w_rdy0;
      r_rdy1    <= w_rdy1;
      r_busy    <= w_busy;
      r_gid     <= w_gid;
      r_rr      <= w_rr;
      r_bit     <= w_bit;
      r_gap     <= w_gap;
      r_err     <= w_err;
      r_first   <= w_first;
      r_idle_hi <= w_idle_hi;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_tx_ctrl = r_tx_ctrl;
    w_tx_data = r_tx_data;
    w_rdy0    = 1'b0;
    w_rdy1    = 1'b0;
    w_gid     = r_gid;
    w_rr      = r_rr;
    w_bit     = r_bit;
    w_gap     = r_gap;
    w_err     = r_err;
    w_first   = r_first;
    w_win1    = 1'b0;
    w_done    = 1'b0;
    // Remember whether sending was already high last IDLE cycle.
    w_idle_hi = (r_state == S_IDLE) &&
                state_tx_sending;
    case (r_state)
      S_IDLE: begin
        w_tx_ctrl = 8'h00;
        if (r_first && state_tx_sending &&
            r_idle_hi)
          w_err = 1'b1;
        if (req0_valid || req1_valid) begin
          // On a tie the requester not named by rr wins.
          w_win1    = req1_valid &&
                      (!req0_valid || !r_rr);
          w_rdy0    = !w_win1;
          w_rdy1    = w_win1;
          w_tx_data = w_win1 ? req1_data
                             : req0_data;
          w_gid     = w_win1;
          w_rr      = w_win1;
          w_tx_ctrl = 8'h01;
          w_state   = S_START;
        end
      end
      S_START: begin
        w_tx_ctrl = 8'h02;
        w_bit     = 4'd0;
        w_state   = S_DATA;
      end
      S_DATA: begin
        if (r_bit != 4'd0 && !state_tx_sending)
          w_err = 1'b1;
        if (r_bit == 4'd8) begin
          w_tx_ctrl = 8'h00;
          w_gap     = '0;
          w_first   = 1'b1;
          w_done    = 1'b1;
          w_state   = (GAP_CYCLES == 0) ? S_IDLE
                                        : S_GAP;
        end else begin
          w_bit = r_bit + 4'd1;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST)
          w_state = S_IDLE;
        else
          w_gap = r_gap + 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

`ifdef UART_TX_SCHED_CNT_EN
  logic [15:0] r_frames;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_frames <= 16'h0000;
    else if (w_done)
      r_frames <= r_frames + 16'h0001;
  end
  assign frames_sent = r_frames;
`else
  logic w_unused_done;
  assign w_unused_done = w_done;
`endif

  assign req0_ready = r_rdy0;
  assign req1_ready = r_rdy1;
  assign tx_data    = r_tx_data;
  assign tx_ctrl    = r_tx_ctrl;
  assign busy       = r_busy;
  assign grant_id   = r_gid;
  assign proto_err  = r_err;

endmodule
